// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared constants and types for the seven-segment scan driver.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Active-low gfedcba patterns for hex digits 0..F.
    localparam logic [6:0] SEG_TABLE [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [0:0] {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } slot_state_e;

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_decode
// Description : Combinational hex nibble to active-low segment lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_segments
);

    assign o_segments = SEG_TABLE[i_nibble];

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Time-multiplexed common-anode 7-segment driver with frame-
//               synchronous double buffering and an anti-ghosting blank gap.
//               Optional macro SEG7_LEADING_ZERO_BLANK_EN darkens leading zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic [N_DIGITS-1:0]     dp,
    input  logic [N_DIGITS-1:0]     digit_en,
    output logic [7:0]              cathodes,
    output logic [N_DIGITS-1:0]     anodes,
    output logic                    frame_tick
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam slot_state_e STATE_RST = (BLANK_CYCLES > 0) ? S_BLANK : S_DRIVE;

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    slot_state_e             state_q, state_d;

    logic [4*N_DIGITS-1:0]   pend_value_q, pend_value_d;
    logic [N_DIGITS-1:0]     pend_dp_q, pend_dp_d;
    logic [N_DIGITS-1:0]     pend_en_q, pend_en_d;
    logic                    pend_valid_q, pend_valid_d;

    logic [4*N_DIGITS-1:0]   act_value_q, act_value_d;
    logic [N_DIGITS-1:0]     act_dp_q, act_dp_d;
    logic [N_DIGITS-1:0]     act_en_q, act_en_d;

    logic [7:0]              cathodes_q, cathodes_d;
    logic [N_DIGITS-1:0]     anodes_q, anodes_d;
    logic                    frame_tick_q, frame_tick_d;

    logic                    w_cnt_wrap;
    logic                    w_idx_wrap;
    logic                    w_frame_end;
    logic                    w_next_blank;
    logic [3:0]              w_nibble;
    logic [6:0]              w_segments;
    logic [N_DIGITS-1:0]     w_lz_dark;
    logic                    w_digit_on;

    assign w_cnt_wrap  = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    assign w_idx_wrap  = (idx_q == IDX_W'(N_DIGITS - 1));
    assign w_frame_end = w_cnt_wrap & w_idx_wrap;

    always_comb begin
        cnt_d = w_cnt_wrap ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (w_cnt_wrap) begin
            idx_d = w_idx_wrap ? '0 : idx_q + 1'b1;
        end
    end

    // The slot state is registered alongside the counter so it tracks cnt_q.
    generate
        if (BLANK_CYCLES > 0) begin : g_blank
            assign w_next_blank = (cnt_d < CNT_W'(BLANK_CYCLES));
        end else begin : g_no_blank
            assign w_next_blank = 1'b0;
        end
    endgenerate

    assign state_d = w_next_blank ? S_BLANK : S_DRIVE;

    // Boundary swap happens before the load capture, so a load in the
    // boundary cycle lands in pending and waits for the next frame.
    always_comb begin
        pend_value_d = pend_value_q;
        pend_dp_d    = pend_dp_q;
        pend_en_d    = pend_en_q;
        pend_valid_d = pend_valid_q;
        act_value_d  = act_value_q;
        act_dp_d     = act_dp_q;
        act_en_d     = act_en_q;
        if (w_frame_end && pend_valid_q) begin
            act_value_d  = pend_value_q;
            act_dp_d     = pend_dp_q;
            act_en_d     = pend_en_q;
            pend_valid_d = 1'b0;
        end
        if (load) begin
            pend_value_d = value;
            pend_dp_d    = dp;
            pend_en_d    = digit_en;
            pend_valid_d = 1'b1;
        end
    end

    assign w_nibble = act_value_q[{idx_q, 2'b00} +: 4];

    seg7_decode u_decode (
        .i_nibble   (w_nibble),
        .o_segments (w_segments)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic w_upper_zero;

    // Scan from the top digit down; a digit is dark while every nibble at or
    // above it is zero, unless its own decimal point is lit.
    always_comb begin
        w_upper_zero = 1'b1;
        w_lz_dark    = '0;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            w_upper_zero = w_upper_zero & (act_value_q[4*i +: 4] == 4'h0);
            w_lz_dark[i] = w_upper_zero & ~act_dp_q[i];
        end
    end
`else
    assign w_lz_dark = '0;
`endif

    assign w_digit_on = act_en_q[idx_q] & ~w_lz_dark[idx_q];

    always_comb begin
        cathodes_d   = {1'b1, SEG_BLANK};
        anodes_d     = '1;
        frame_tick_d = w_frame_end;
        if (state_q == S_DRIVE) begin
            cathodes_d = {~act_dp_q[idx_q], w_segments};
            if (w_digit_on) begin
                anodes_d = ~(N_DIGITS'(1) << idx_q);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            state_q      <= STATE_RST;
            pend_value_q <= '0;
            pend_dp_q    <= '0;
            pend_en_q    <= '0;
            pend_valid_q <= 1'b0;
            act_value_q  <= '0;
            act_dp_q     <= '0;
            act_en_q     <= '0;
            cathodes_q   <= 8'hFF;
            anodes_q     <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            state_q      <= state_d;
            pend_value_q <= pend_value_d;
            pend_dp_q    <= pend_dp_d;
            pend_en_q    <= pend_en_d;
            pend_valid_q <= pend_valid_d;
            act_value_q  <= act_value_d;
            act_dp_q     <= act_dp_d;
            act_en_q     <= act_en_d;
            cathodes_q   <= cathodes_d;
            anodes_q     <= anodes_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign cathodes   = cathodes_q;
    assign anodes     = anodes_q;
    assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Randomized scoreboard bench for seg7_scan_driver (4 digits,
//               8-cycle slots, 2 blank cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int NR = ND * RD;
    localparam int FRAMES = 12;
    localparam int EDGES  = (FRAMES + 1) * NR;

    typedef struct packed {
        logic [15:0] v;
        logic [3:0]  dp;
        logic [3:0]  en;
    } frame_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  digit_en;
    logic [7:0]  cathodes;
    logic [3:0]  anodes;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;
    frame_t exp_q[$];

    seg7_scan_driver #(
        .N_DIGITS     (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load),
        .value      (value),
        .dp         (dp),
        .digit_en   (digit_en),
        .cathodes   (cathodes),
        .anodes     (anodes),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] seg_ref(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic bit lz_dark(input frame_t fr, input int d);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        return (d != 0) && ((fr.v >> (4 * d)) == 16'h0) && !fr.dp[d];
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [15:0] rand_value();
        logic [15:0] r = '0;
        for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 2) != 0) r[4*k +: 4] = 4'($urandom_range(0, 15));
        end
        return r;
    endfunction

    // Stimulus plus frame-level reference model of the double buffer.
    task automatic stimulus();
        frame_t pend = '0;
        frame_t act  = '0;
        bit     pv   = 1'b0;
        for (int e = 1; e <= EDGES; e++) begin
            load = 1'b0;
            if (e == 3) begin
                load = 1'b1; value = 16'h1234; dp = 4'h0; digit_en = 4'hF;
            end else if (e == NR + 3) begin
                load = 1'b1; value = 16'hAAAA; dp = 4'h0; digit_en = 4'hF;
            end else if (e == NR + 5) begin
                load = 1'b1; value = 16'h6E6E; dp = 4'h0; digit_en = 4'hF;
            end else if (e == 3 * NR) begin
                load = 1'b1; value = 16'h0070; dp = 4'h0; digit_en = 4'hF;
            end else if (e == 4 * NR + 4) begin
                load = 1'b1; value = 16'h5A5A; dp = 4'b0001; digit_en = 4'b0101;
            end else if (e > 5 * NR) begin
                if ((e % NR == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 11) == 0)) begin
                    load     = 1'b1;
                    value    = rand_value();
                    dp       = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(0, 15));
                    digit_en = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(0, 15));
                end
            end
            @(posedge clk);
            if (e % NR == 0) begin
                if (pv) begin
                    act = pend;
                    pv  = 1'b0;
                end
                exp_q.push_back(act);
            end
            if (load) begin
                pend = '{v: value, dp: dp, en: digit_en};
                pv   = 1'b1;
            end
            #1;
            load = 1'b0;
        end
    endtask

    task automatic monitor();
        int  n    = 0;
        bit  seen = 1'b0;
        while (!seen && n < NR + 4) begin
            @(negedge clk);
            n++;
            if (frame_tick) seen = 1'b1;
            else chk("pre_frame_dark", 32'(anodes), 32'hF);
        end
        chk("first_tick_seen", 32'(seen), 32'd1);
        if (!seen) return;
        chk("first_tick_cycle", 32'(n), 32'(NR));
        for (int f = 0; f < FRAMES; f++) begin
            frame_t fr = '0;
            chk("scoreboard_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) fr = exp_q.pop_front();
            for (int j = 0; j < NR; j++) begin
                int d = j / RD;
                int s = j % RD;
                logic [3:0] exp_an;
                logic [7:0] exp_cat;
                @(negedge clk);
                if (s < BC) begin
                    exp_an  = 4'hF;
                    exp_cat = 8'hFF;
                end else begin
                    exp_an  = (fr.en[d] && !lz_dark(fr, d)) ? ~(4'b0001 << d) : 4'hF;
                    exp_cat = {~fr.dp[d], seg_ref(4'((fr.v >> (4 * d)) & 16'hF))};
                end
                chk($sformatf("f%0d_c%0d_anodes", f, j), 32'(anodes), 32'(exp_an));
                chk($sformatf("f%0d_c%0d_cathodes", f, j), 32'(cathodes), 32'(exp_cat));
                chk($sformatf("f%0d_c%0d_frame_tick", f, j), 32'(frame_tick), 32'(j == NR - 1));
            end
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        load     = 1'b0;
        value    = '0;
        dp       = '0;
        digit_en = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_cathodes", 32'(cathodes), 32'hFF);
        chk("reset_anodes", 32'(anodes), 32'hF);
        chk("reset_frame_tick", 32'(frame_tick), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        fork
            stimulus();
            monitor();
        join

        // Leave a valid pending load, then reset asynchronously mid-DRIVE.
        value = 16'h1234; dp = 4'h0; digit_en = 4'hF; load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_anodes", 32'(anodes), 32'hF);
        chk("async_reset_cathodes", 32'(cathodes), 32'hFF);
        chk("async_reset_frame_tick", 32'(frame_tick), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 2 * NR + 2; k++) begin
            @(negedge clk);
            chk($sformatf("post_reset_dark_c%0d", k), 32'(anodes), 32'hF);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for an N-digit common-anode seven-segment display. It takes a packed hex value, a decimal-point mask and a digit-enable mask, and scans the digits with a programmable dwell and an anti-ghosting blanking gap. A double buffer applies new values only at frame boundaries, so the display never shows a mix of old and new digits. It sits between the core's memory-mapped display register and the board pins.

## Interface
- `N_DIGITS`, 4: number of digits scanned (1–8).
- `REFRESH_DIV`, 100000: clock cycles per digit slot (≥2).
- `BLANK_CYCLES`, 1000: cycles at the start of each slot with all anodes off (0 ≤ `BLANK_CYCLES` < `REFRESH_DIV`).
- `clk`, in, 1: system clock.
- `reset_n`, in, 1: reset, asynchronous assert, active-low. One clock domain; reset is asynchronous and active-low.
- `load`, in, 1: one-cycle strobe that captures `value`, `dp` and `digit_en` into the pending buffer.
- `value`, in, 4·`N_DIGITS`: hex nibbles; `value[3:0]` is digit 0 (rightmost).
- `dp`, in, `N_DIGITS`: decimal point per digit, 1 = lit.
- `digit_en`, in, `N_DIGITS`: per-digit enable, 0 = digit dark.
- `cathodes`, out, 8: active-low segments; `[7]` = dp, `[6:0]` = g,f,e,d,c,b,a.
- `anodes`, out, `N_DIGITS`: active-low digit selects; at most one is low at any time.
- `frame_tick`, out, 1: one-cycle pulse at each frame boundary.

## Operation
- Reset values:
  - `cathodes` = 8'hFF, `anodes` = all 1, `frame_tick` = 0.
  - Slot counter = 0, digit index = 0.
  - Pending and active buffers = 0, including `digit_en`, so the display is dark until the first load reaches a frame boundary.
- Double buffering:
  - `load` copies the inputs to the pending buffer and sets `pend_valid`.
  - At a frame boundary, if `pend_valid` is set, active is updated from pending and `pend_valid` is cleared.
  - A second `load` before the boundary overwrites pending; the last load wins.
- Simultaneous events: `load` in the boundary cycle is captured into pending. Active takes the earlier pending contents, and the new data is applied at the following boundary.
- Slot counter counts 0..`REFRESH_DIV`−1. At wrap, the digit index increments modulo `N_DIGITS`. Index wrap from `N_DIGITS`−1 to 0 is the frame boundary.
- Per-slot state machine for the current index `i`:
  - BLANK (counter < `BLANK_CYCLES`): anodes all 1, cathodes 8'hFF.
  - DRIVE (remaining cycles): `anodes[i]` = 0 if active `digit_en[i]`, otherwise all 1.
  - In DRIVE, `cathodes[6:0]` = decode(nibble `i`) and `cathodes[7]` = ~dp[i].
  - A disabled digit still consumes its full slot.
- Decode, active-low gfedcba:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- With `BLANK_CYCLES` = 0 there is no BLANK state; DRIVE fills the slot.
- Reset mid-frame: outputs go to reset values immediately (asynchronously), and both buffers are cleared.

## Timing
- All outputs are registered; there is no combinational path from inputs to pins.
- `load` at edge t: pending valid after edge t. Visible on pins no later than one frame (`N_DIGITS`·`REFRESH_DIV` cycles) plus 1 cycle.
- After reset release: the first slot is digit 0, starting in BLANK. Output changes lag the counter by 1 register stage, uniformly.
- `frame_tick` is high for exactly 1 cycle every `N_DIGITS`·`REFRESH_DIV` cycles, in the same cycle the active buffer updates.
- Counter width = $clog2(`REFRESH_DIV`); index width = max(1, $clog2(`N_DIGITS`)).

## Configuration
- Macro: `SEG7_LEADING_ZERO_BLANK_EN`.
- Defined: digits above the most-significant non-zero nibble of active `value` are forced dark (anode off), independent of `digit_en`. Digit 0 is never blanked by this rule. A lit dp on a digit exempts it from blanking.
- Undefined: only `digit_en` controls darkness, and zeros display as "0".

## Structure
- `seg7_pkg` holds:
  - The 16-entry segment table as a constant array.
  - `SEG_BLANK` = 7'h7F.
  - The slot state enum {`S_BLANK`, `S_DRIVE`}.
- Sub-module `seg7_decode`: combinational nibble to 7-bit segment lookup from the package table. Instantiated once on the muxed nibble.
- The top level contains the counter, index, state register, buffers, leading-zero logic and output registers.

## Test plan
All cases use `N_DIGITS`=4, `REFRESH_DIV`=8, `BLANK_CYCLES`=2.
1. Reset: hold `reset_n`=0 mid-DRIVE -> `anodes`=4'hF and `cathodes`=8'hFF in the same cycle; after release, display stays dark for ≥1 frame with no load.
2. Load `value`=16'h1234, `digit_en`=4'hF, `dp`=0 -> after the next `frame_tick`:
   - digit0 cathodes 7'b0011001 ("4"), anode 4'b1110, for 6 cycles after 2 blank cycles.
   - digits 1..3 show "3", "2", "1".
3. Load 16'hAAAA, then 16'h6E6E two cycles later within the same frame -> only "6"/"E" (0000010/0000110) ever appear; no 'A'.
4. `load` asserted in the `frame_tick` cycle -> old pending applied now; the new value appears one frame later.
5. `digit_en`=4'b0101, `dp`=4'b0001 -> anodes never low for digits 1 and 3; `cathodes[7]`=0 only during digit 0 DRIVE.
6. With `SEG7_LEADING_ZERO_BLANK_EN`, `value`=16'h0070 -> digits 2 and 3 dark, digits 1 and 0 show "7" and "0". Without the macro -> "0070".
